// File: rtl/ldpcsp_cycle_sequencer.sv
// T-state / M-cycle sequencer for the microcoded core: one-hot step and cycle
// drives, opcode latch, HALT handling and a sticky M-cycle overrun flag.
module ldpcsp_cycle_sequencer (
    input  logic       i_Clk,
    input  logic       i_Rst_n,
    input  logic       i_Wait,
    input  logic       i_Reset_Cycle,
    input  logic       i_IR_Fetch,
    input  logic       i_Halt_Req,
    input  logic       i_Wake,
    input  logic [7:0] i_Data_Bus,
    output logic [3:0] o_Cycle_Step,
    output logic [7:0] o_Cycle_Count,
    output logic [7:0] o_IR,
    output logic       o_IR_Valid,
    output logic       o_Halted,
    output logic       o_Overrun
);

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_t;

    state_t      state_r;
    state_t      state_s;
    logic [3:0]  step_r;
    logic [3:0]  step_s;
    logic [7:0]  count_r;
    logic [7:0]  count_s;
    logic [7:0]  ir_r;
    logic [7:0]  ir_s;
    logic        ir_valid_r;
    logic        ir_valid_s;
    logic        halted_r;
    logic        halted_s;
    logic        overrun_r;
    logic        overrun_s;

    function automatic logic [3:0] rotl_step(input logic [3:0] step);
        return {step[2:0], step[3]};
    endfunction

    // Ninth M-cycle without a reset-cycle wraps back to the first one.
    function automatic logic [7:0] next_count(input logic [7:0] count, input logic reset_cycle);
        logic [7:0] result;
        if (reset_cycle) begin
            result = 8'h01;
        end else if (count == 8'h80) begin
            result = 8'h01;
        end else begin
            result = {count[6:0], 1'b0};
        end
        return result;
    endfunction

    // Next-state and next-output decode for the RUN/HALT sequencer.
    always_comb begin
        state_s    = state_r;
        step_s     = step_r;
        count_s    = count_r;
        ir_s       = ir_r;
        ir_valid_s = 1'b0;
        halted_s   = halted_r;
        overrun_s  = overrun_r;
        case (state_r)
            ST_RUN: begin
                if (!i_Wait) begin
                    step_s = rotl_step(step_r);
                    if (step_r[3]) begin
                        count_s = next_count(count_r, i_Reset_Cycle);
                        if (!i_Reset_Cycle && (count_r == 8'h80)) begin
                            overrun_s = 1'b1;
                        end else begin
                            overrun_s = overrun_r;
                        end
                        if (i_IR_Fetch) begin
                            ir_s       = i_Data_Bus;
                            ir_valid_s = 1'b1;
                        end else begin
                            ir_s       = ir_r;
                            ir_valid_s = 1'b0;
                        end
                        // Step already rotates 1000->0001 and count resets, so HALT starts clean.
                        if (i_Halt_Req && i_Reset_Cycle && !i_Wake) begin
                            state_s  = ST_HALT;
                            halted_s = 1'b1;
                        end else begin
                            state_s  = ST_RUN;
                            halted_s = 1'b0;
                        end
                    end else begin
                        count_s = count_r;
                    end
                end else begin
                    step_s = step_r;
                end
            end
            ST_HALT: begin
                if (i_Wake) begin
                    state_s  = ST_RUN;
                    halted_s = 1'b0;
                end else begin
                    state_s  = ST_HALT;
                    halted_s = 1'b1;
                end
            end
            default: begin
                state_s  = ST_RUN;
                halted_s = 1'b0;
            end
        endcase
    end

    // Sequencer state and output registers with asynchronous reset.
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state_r    <= ST_RUN;
            step_r     <= 4'b0001;
            count_r    <= 8'h01;
            ir_r       <= 8'h00;
            ir_valid_r <= 1'b0;
            halted_r   <= 1'b0;
            overrun_r  <= 1'b0;
        end else begin
            state_r    <= state_s;
            step_r     <= step_s;
            count_r    <= count_s;
            ir_r       <= ir_s;
            ir_valid_r <= ir_valid_s;
            halted_r   <= halted_s;
            overrun_r  <= overrun_s;
        end
    end

    assign o_Cycle_Step  = step_r;
    assign o_Cycle_Count = count_r;
    assign o_IR          = ir_r;
    assign o_IR_Valid    = ir_valid_r;
    assign o_Halted      = halted_r;
    assign o_Overrun     = overrun_r;

endmodule
